// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect flushes and memory-wait freezes.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEMWAIT_MAX  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [31:0]      inst_id,
  input  logic [31:0]      inst_exe,
  input  logic             MemRead_exe,
  input  logic             RegWrite_exe,
  input  logic             taken_exe,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idexe_bubble,
  output logic             idexe_stall,
  output logic             exmem_stall,
  output logic             mem_timeout,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEMWAIT_MAX + 1);
  localparam int FL_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [WAIT_W-1:0] WAIT_ONE     = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST    = WAIT_W'(MEMWAIT_MAX);
  localparam logic [FL_W-1:0]   FLUSH_RELOAD = FL_W'(FLUSH_CYCLES - 1);
  localparam logic [FL_W-1:0]   FLUSH_ONE    = FL_W'(1);

  localparam logic [6:0] OP_ARITH    = 7'b0110011;
  localparam logic [6:0] OP_COND_BRA = 7'b1100011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_JAL      = 7'b1101111;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  state_t            ret_reg, ret_next;
  state_t            eff_state;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [FL_W-1:0]   left_reg, left_next;
  logic              block_reg, block_next;
  logic              timeout_reg, timeout_next;

  logic [4:0] rd_exe, rs1_id, rs2_id;
  logic [6:0] op_id;
  logic       uses_rs1, uses_rs2, loaduse;
  logic       timeout_now, blocked, taken_act;
  logic       pc_stall_c, ifid_stall_c, ifid_flush_c, idexe_bubble_c;
  logic       idexe_stall_c, exmem_stall_c;

  assign rd_exe = inst_exe[11:7];
  assign rs1_id = inst_id[19:15];
  assign rs2_id = inst_id[24:20];
  assign op_id  = inst_id[6:0];

  // Only the register fields and ID opcode matter to hazard detection.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst_exe[31:12], inst_exe[6:0], inst_id[31:25], inst_id[14:7]};

  assign uses_rs1 = (op_id != OP_JAL);
  assign uses_rs2 = (op_id == OP_ARITH) || (op_id == OP_COND_BRA) || (op_id == OP_STORE);
  assign loaduse  = MemRead_exe && RegWrite_exe && (rd_exe != 5'd0) &&
                    ((uses_rs1 && (rd_exe == rs1_id)) || (uses_rs2 && (rd_exe == rs2_id)));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg   <= ST_RUN;
      ret_reg     <= ST_RUN;
      wait_reg    <= '0;
      left_reg    <= '0;
      block_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ret_reg     <= ret_next;
      wait_reg    <= wait_next;
      left_reg    <= left_next;
      block_reg   <= block_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ret_next       = ret_reg;
    wait_next      = wait_reg;
    left_next      = left_reg;
    block_next     = block_reg;
    timeout_next   = timeout_reg;
    eff_state      = state_reg;
    timeout_now    = 1'b0;
    taken_act      = 1'b0;
    pc_stall_c     = 1'b0;
    ifid_stall_c   = 1'b0;
    ifid_flush_c   = 1'b0;
    idexe_bubble_c = 1'b0;
    idexe_stall_c  = 1'b0;
    exmem_stall_c  = 1'b0;

    // Leaving MEMWAIT (release or timeout) hands this same cycle to the return state.
    if (state_reg == ST_MEMWAIT) begin
      if (mem_busy && (wait_reg != WAIT_LAST)) begin
        pc_stall_c    = 1'b1;
        ifid_stall_c  = 1'b1;
        idexe_stall_c = 1'b1;
        exmem_stall_c = 1'b1;
        wait_next     = wait_reg + WAIT_W'(1);
      end else begin
        timeout_now = mem_busy;
        eff_state   = ret_reg;
        state_next  = ret_reg;
      end
    end

    blocked = block_reg || timeout_now;

    case (eff_state)
      ST_RUN: begin
        state_next = ST_RUN;
        if (mem_busy && !blocked) begin
          pc_stall_c    = 1'b1;
          ifid_stall_c  = 1'b1;
          idexe_stall_c = 1'b1;
          exmem_stall_c = 1'b1;
          state_next    = ST_MEMWAIT;
          ret_next      = ST_RUN;
          wait_next     = WAIT_ONE;
        end else if (taken_exe) begin
          ifid_flush_c   = 1'b1;
          idexe_bubble_c = 1'b1;
          taken_act      = 1'b1;
          left_next      = FLUSH_RELOAD;
          state_next     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end else if (loaduse) begin
          pc_stall_c     = 1'b1;
          ifid_stall_c   = 1'b1;
          idexe_bubble_c = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (mem_busy && !blocked) begin
          // The pending flush cycle is preserved across the freeze.
          pc_stall_c    = 1'b1;
          ifid_stall_c  = 1'b1;
          idexe_stall_c = 1'b1;
          exmem_stall_c = 1'b1;
          state_next    = ST_MEMWAIT;
          ret_next      = ST_FLUSH;
          wait_next     = WAIT_ONE;
        end else begin
          ifid_flush_c = 1'b1;
          if (taken_exe) begin
            idexe_bubble_c = 1'b1;
            taken_act      = 1'b1;
            left_next      = FLUSH_RELOAD;
            state_next     = ST_FLUSH;
          end else if (left_reg <= FLUSH_ONE) begin
            left_next  = '0;
            state_next = ST_RUN;
          end else begin
            left_next  = left_reg - FL_W'(1);
            state_next = ST_FLUSH;
          end
        end
      end
      ST_MEMWAIT: begin
        state_next = ST_MEMWAIT;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase

    if (timeout_now) begin
      block_next   = 1'b1;
      timeout_next = 1'b1;
    end else if (!mem_busy) begin
      block_next = 1'b0;
    end
  end

  assign pc_stall     = pc_stall_c     & nrst;
  assign ifid_stall   = ifid_stall_c   & nrst;
  assign ifid_flush   = ifid_flush_c   & nrst;
  assign idexe_bubble = idexe_bubble_c & nrst;
  assign idexe_stall  = idexe_stall_c  & nrst;
  assign exmem_stall  = exmem_stall_c  & nrst;
  assign mem_timeout  = timeout_reg;
  assign hz_state     = state_reg;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (pc_stall_c && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (taken_act && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`else
  logic unused_taken_act;
  assign unused_taken_act = taken_act;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
